bsg_segment_assembler: RTL

- Inverse of a wide-to-narrow segmented register path: accepts a stream of `seg_width_p`-bit segments and packs `els_p` of them into one wide word.
- Presents the word on a valid/yumi output interface.
- Sits on the receive side of a narrow link and rebuilds the full-width payload (e.g. 16-bit segments back to 64-bit words) before wide consumers.
- Supports back-to-back words with no bubble when the consumer dequeues promptly.

---
 rtl/bsg_segment_pkg.sv | 14 +
 rtl/bsg_segment_assembler_chk.sv | 28 ++
 rtl/bsg_segment_assembler_slot.sv | 28 ++
 rtl/bsg_segment_assembler.sv | 120 ++++++++++++
 4 files changed

// File: rtl/bsg_segment_pkg.sv
// Shared types and helpers for the segment assembler: FSM state encoding
// and the width of the segment counter.
package bsg_segment_pkg;

  typedef enum logic {
    eFill = 1'b0,
    eFull = 1'b1
  } bsg_seg_asm_state_e;

  function automatic int seg_count_width(input int els);
    return $clog2(els + 1);
  endfunction

endpackage : bsg_segment_pkg

// File: rtl/bsg_segment_assembler_chk.sv
// Nonsynthesizable protocol checks for the segment assembler: dequeue
// without a valid word, and an unstable producer while stalled.
module bsg_segment_assembler_chk #(
  parameter int seg_width_p = 16,
  parameter int els_p       = 4
) (
  input logic                   clk_i,
  input logic                   reset_n_i,
  input logic                   v_i,
  input logic [seg_width_p-1:0] data_i,
  input logic                   ready_o,
  input logic                   v_o,
  input logic                   yumi_i
);

  if (els_p < 2) begin : g_bad_els
    $fatal(1, "bsg_segment_assembler: els_p must be at least 2");
  end

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(yumi_i && !v_o))
    else $error("bsg_segment_assembler: yumi_i asserted while v_o is low");

  a_hold_while_stalled: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (v_i && !ready_o) |=> (v_i && $stable(data_i)))
    else $warning("bsg_segment_assembler: producer dropped v_i or changed data_i while stalled");

endmodule : bsg_segment_assembler_chk

// File: rtl/bsg_segment_assembler_slot.sv
// One segment-wide storage slot of the assembled word: loads on enable,
// clears asynchronously on reset.
module bsg_segment_assembler_slot #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] r_data;

  // Slot storage; holds unless this slot is the one being written.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_data <= '0;
    end else if (en_i) begin
      r_data <= data_i;
    end else begin
      r_data <= r_data;
    end
  end

  assign data_o = r_data;

endmodule : bsg_segment_assembler_slot

// File: rtl/bsg_segment_assembler.sv
// Packs els_p narrow segments into one wide word and presents it on a
// valid/yumi interface; a new word may start filling on the dequeue edge.
module bsg_segment_assembler
  import bsg_segment_pkg::*;
#(
  parameter int seg_width_p = 16,
  parameter int els_p       = 4,
  parameter bit msb_first_p = 1'b0
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             v_i,
  input  logic [seg_width_p-1:0]           data_i,
  output logic                             ready_o,
  output logic                             v_o,
  output logic [els_p*seg_width_p-1:0]     data_o,
  input  logic                             yumi_i,
  output logic [seg_count_width(els_p)-1:0] count_o
);

  localparam int cw_lp = seg_count_width(els_p);
  localparam logic [cw_lp-1:0] last_lp = cw_lp'(els_p - 1);

  bsg_seg_asm_state_e r_state, w_state_n;
  logic [cw_lp-1:0]   r_count, w_count_n;
  logic [cw_lp-1:0]   w_slot;
  logic [els_p-1:0]   w_en;
  logic               w_accept;

  // A full word blocks input unless it is being dequeued this same cycle.
  assign ready_o  = reset_n_i & ((r_state == eFill) | yumi_i);
  assign w_accept = v_i & ready_o;
  assign v_o      = (r_state == eFull);
  assign count_o  = r_count;

  // State and segment counter registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= eFill;
      r_count <= '0;
    end else begin
      r_state <= w_state_n;
      r_count <= w_count_n;
    end
  end

  // Next-state logic; on dequeue-with-accept the counter restarts at one.
  always_comb begin
    w_state_n = r_state;
    w_count_n = r_count;
    case (r_state)
      eFill: begin
        if (w_accept) begin
          if (r_count == last_lp) begin
            w_state_n = eFull;
            w_count_n = '0;
          end else begin
            w_count_n = r_count + cw_lp'(1);
          end
        end else begin
          w_count_n = r_count;
        end
      end
      eFull: begin
        if (yumi_i) begin
          w_state_n = eFill;
          if (w_accept) begin
            w_count_n = cw_lp'(1);
          end else begin
            w_count_n = '0;
          end
        end else begin
          w_state_n = eFull;
        end
      end
      default: begin
        w_state_n = eFill;
        w_count_n = '0;
      end
    endcase
  end

  // r_count is already zero in eFull, so it names the slot in both states.
  always_comb begin
    w_slot = r_count;
    if (msb_first_p) begin
      w_slot = last_lp - r_count;
    end else begin
      w_slot = r_count;
    end
  end

  for (genvar i = 0; i < els_p; i++) begin : g_slot
    assign w_en[i] = w_accept & (w_slot == cw_lp'(i));

    bsg_segment_assembler_slot #(
      .width_p(seg_width_p)
    ) u_slot (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .en_i     (w_en[i]),
      .data_i   (data_i),
      .data_o   (data_o[i*seg_width_p +: seg_width_p])
    );
  end

  bsg_segment_assembler_chk #(
    .seg_width_p(seg_width_p),
    .els_p      (els_p)
  ) u_chk (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (v_i),
    .data_i   (data_i),
    .ready_o  (ready_o),
    .v_o      (v_o),
    .yumi_i   (yumi_i)
  );

endmodule : bsg_segment_assembler
